// File: rtl/sys_cpu_oci_pkg.sv
// sys_cpu_oci_pkg: shared jdo field positions, data width and JTAG FSM states for the OCI memory controller
package sys_cpu_oci_pkg;
  localparam int DW = 32;
  localparam int JDO_RD_BIT = 35;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_DATA_LSB = 3;
  typedef enum logic [1:0] {JT_IDLE, JT_RD, JT_CAP, JT_WR} jt_state_t;
endpackage

// File: rtl/sys_cpu_oci_ram.sv
// sys_cpu_oci_ram: single-port 2**AW x 32 monitor RAM with byte enables and registered read
module sys_cpu_oci_ram
  import sys_cpu_oci_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    q <= mem[addr];
  end
endmodule

// File: rtl/sys_cpu_oci_mem_ctrl.sv
// sys_cpu_oci_mem_ctrl: JTAG/Avalon arbitrated OCI debug memory controller.
// Define SYS_CPU_OCIMEM_DEBUGACCESS_EN to block Avalon writes made without avl_debugaccess.
module sys_cpu_oci_mem_ctrl
  import sys_cpu_oci_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW-1:0] avl_address,
  input  logic          avl_read,
  input  logic          avl_write,
  input  logic [DW-1:0] avl_writedata,
  input  logic [3:0]    avl_byteenable,
  input  logic          avl_debugaccess,
  output logic [DW-1:0] avl_readdata,
  output logic          avl_waitrequest,
  output logic [DW-1:0] MonDReg,
  output logic [AW-1:0] MonAReg,
  output logic          jtag_busy
);
  jt_state_t jt_q, jt_d;
  logic av_q, av_d;
  logic idle, b_go, a_go, n_go, jtag_owns, av_rd_go, av_wr_go, wr_ok, unused;
  logic ram_we;
  logic [3:0] ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_q;
`ifdef SYS_CPU_OCIMEM_DEBUGACCESS_EN
  assign wr_ok = avl_debugaccess;
  assign unused = ^{jdo[37:36], jdo[2:0]};
`else
  assign wr_ok = 1'b1;
  assign unused = ^{jdo[37:36], jdo[2:0], avl_debugaccess};
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      jt_q <= JT_IDLE;
      av_q <= 1'b0;
      MonDReg <= '0;
      MonAReg <= '0;
    end else begin
      jt_q <= jt_d;
      av_q <= av_d;
      MonDReg <= b_go ? jdo[JDO_DATA_MSB:JDO_DATA_LSB] : (jt_q == JT_CAP) ? ram_q : MonDReg;
      MonAReg <= a_go ? jdo[JDO_ADDR_LSB +: AW] : (n_go || jt_q == JT_WR) ? MonAReg + 1'b1 : MonAReg;
    end
  end
  always_comb begin
    idle = (jt_q == JT_IDLE);
    b_go = idle && take_action_ocimem_b;
    a_go = idle && !take_action_ocimem_b && take_action_ocimem_a;
    n_go = idle && !take_action_ocimem_b && !take_action_ocimem_a && take_no_action_ocimem_a;
    jt_d = b_go ? JT_WR :
           a_go ? (jdo[JDO_RD_BIT] ? JT_RD : JT_IDLE) :
           n_go ? JT_RD :
           (jt_q == JT_RD) ? JT_CAP : JT_IDLE;
    // A strobe cycle already belongs to JTAG even though the FSM is still idle
    jtag_owns = !idle || take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b;
    av_rd_go = !reset && !av_q && avl_read && !jtag_owns;
    av_wr_go = !reset && !av_q && avl_write && !avl_read && !jtag_owns;
    av_d = av_rd_go;
    avl_waitrequest = reset || !(av_q || av_wr_go);
    avl_readdata = (av_q && !reset) ? ram_q : '0;
    jtag_busy = !idle;
    ram_we = !reset && ((jt_q == JT_WR) || (av_wr_go && wr_ok));
    ram_addr = idle ? avl_address : MonAReg;
    ram_wdata = idle ? avl_writedata : MonDReg;
    ram_be = idle ? avl_byteenable : 4'hF;
  end
  sys_cpu_oci_ram #(.AW(AW)) u_ram (
    .clk(clk),
    .we(ram_we),
    .be(ram_be),
    .addr(ram_addr),
    .wdata(ram_wdata),
    .q(ram_q)
  );
endmodule

// File: tb/tb_sys_cpu_oci_mem_ctrl.sv
// tb_sys_cpu_oci_mem_ctrl: directed self-checking bench for the OCI debug memory controller
module tb_sys_cpu_oci_mem_ctrl;
  localparam int AW = 9;
  logic clk = 1'b0;
  logic reset;
  logic [37:0] jdo;
  logic take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [AW-1:0] avl_address;
  logic avl_read, avl_write, avl_debugaccess, avl_waitrequest, jtag_busy;
  logic [31:0] avl_writedata, avl_readdata, MonDReg;
  logic [3:0] avl_byteenable;
  logic [AW-1:0] MonAReg;
  logic [31:0] rd;
  int n;
  int vectors = 0;
  int miscompares = 0;
  sys_cpu_oci_mem_ctrl #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
    .avl_debugaccess(avl_debugaccess), .avl_readdata(avl_readdata),
    .avl_waitrequest(avl_waitrequest), .MonDReg(MonDReg), .MonAReg(MonAReg),
    .jtag_busy(jtag_busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic jtag_a(input logic [AW-1:0] a, input logic rdb);
    jdo = '0;
    jdo[35] = rdb;
    jdo[17 +: AW] = a;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    repeat (3) tick();
  endtask
  task automatic jtag_n();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    repeat (3) tick();
  endtask
  task automatic jtag_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    repeat (3) tick();
  endtask
  task automatic avl_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg);
    logic done;
    done = 1'b0;
    avl_address = a;
    avl_writedata = d;
    avl_byteenable = be;
    avl_debugaccess = dbg;
    avl_write = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = !avl_waitrequest;
      tick();
    end
    avl_write = 1'b0;
    check("avl_wr_done", {31'd0, done}, 32'd1);
  endtask
  task automatic avl_rd(input logic [AW-1:0] a, output logic [31:0] d, output int cyc);
    logic done;
    done = 1'b0;
    cyc = 0;
    d = 'x;
    avl_address = a;
    avl_read = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      cyc++;
      if (!avl_waitrequest) begin
        done = 1'b1;
        d = avl_readdata;
      end
      tick();
    end
    avl_read = 1'b0;
    check("avl_rd_done", {31'd0, done}, 32'd1);
  endtask
  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    avl_address = '0;
    avl_read = 1'b0;
    avl_write = 1'b0;
    avl_writedata = '0;
    avl_byteenable = '0;
    avl_debugaccess = 1'b0;
    repeat (3) tick();
    check("rst_mond", MonDReg, 32'h0);
    check("rst_mona", {23'd0, MonAReg}, 32'h0);
    check("rst_busy", {31'd0, jtag_busy}, 32'h0);
    check("rst_wait", {31'd0, avl_waitrequest}, 32'h1);
    check("rst_rdata", avl_readdata, 32'h0);
    reset = 1'b0;
    tick();
    // JTAG write then read back
    jtag_a(9'h010, 1'b0);
    check("lda_mona", {23'd0, MonAReg}, 32'h010);
    check("lda_busy", {31'd0, jtag_busy}, 32'h0);
    jtag_b(32'hDEADBEEF);
    check("wr_mona", {23'd0, MonAReg}, 32'h011);
    check("wr_echo", MonDReg, 32'hDEADBEEF);
    jtag_a(9'h010, 1'b1);
    check("rd_mond", MonDReg, 32'hDEADBEEF);
    check("rd_mona", {23'd0, MonAReg}, 32'h010);
    // Streaming across the top of memory
    jtag_a(9'h1FD, 1'b0);
    jtag_b(32'h1);
    jtag_b(32'h2);
    jtag_b(32'h3);
    check("wr_wrap_mona", {23'd0, MonAReg}, 32'h000);
    jtag_a(9'h1FD, 1'b1);
    check("str0_mond", MonDReg, 32'h1);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    check("str1_busy", {31'd0, jtag_busy}, 32'h1);
    check("str1_early", MonDReg, 32'h1);
    tick();
    check("str1_mond", MonDReg, 32'h2);
    check("str1_mona", {23'd0, MonAReg}, 32'h1FE);
    check("str1_idle", {31'd0, jtag_busy}, 32'h0);
    tick();
    jtag_n();
    check("str2_mond", MonDReg, 32'h3);
    check("str2_mona", {23'd0, MonAReg}, 32'h1FF);
    jtag_n();
    check("str_wrap", {23'd0, MonAReg}, 32'h000);
    // Avalon read colliding with a JTAG write strobe
    jtag_a(9'h020, 1'b0);
    jdo = '0;
    jdo[34:3] = 32'hCAFEF00D;
    take_action_ocimem_b = 1'b1;
    avl_address = 9'h020;
    avl_read = 1'b1;
    #1;
    check("ct_wait0", {31'd0, avl_waitrequest}, 32'h1);
    tick();
    take_action_ocimem_b = 1'b0;
    #1;
    check("ct_busy1", {31'd0, jtag_busy}, 32'h1);
    check("ct_wait1", {31'd0, avl_waitrequest}, 32'h1);
    tick();
    #1;
    check("ct_busy2", {31'd0, jtag_busy}, 32'h0);
    check("ct_wait2", {31'd0, avl_waitrequest}, 32'h1);
    tick();
    #1;
    check("ct_wait3", {31'd0, avl_waitrequest}, 32'h0);
    check("ct_rdata", avl_readdata, 32'hCAFEF00D);
    tick();
    avl_read = 1'b0;
    check("ct_mona", {23'd0, MonAReg}, 32'h021);
    // Byte enables and read/write collision on the Avalon side
    avl_wr(9'h000, 32'h0, 4'hF, 1'b1);
    avl_wr(9'h000, 32'hAABBCCDD, 4'b0101, 1'b1);
    avl_rd(9'h000, rd, n);
    check("be_rdata", rd, 32'h00BB00DD);
    check("rd_latency", n, 32'd2);
    avl_writedata = 32'hFFFFFFFF;
    avl_byteenable = 4'hF;
    avl_write = 1'b1;
    avl_rd(9'h000, rd, n);
    avl_write = 1'b0;
    check("rw_rdata", rd, 32'h00BB00DD);
    avl_rd(9'h000, rd, n);
    check("rw_nowrite", rd, 32'h00BB00DD);
    jtag_a(9'h000, 1'b1);
    check("avl_to_jtag", MonDReg, 32'h00BB00DD);
    // Reset in the middle of a JTAG write
    avl_wr(9'h040, 32'h99, 4'hF, 1'b1);
    jtag_a(9'h040, 1'b0);
    jdo = '0;
    jdo[34:3] = 32'h1234;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    reset = 1'b1;
    #1;
    check("mr_wait", {31'd0, avl_waitrequest}, 32'h1);
    tick();
    reset = 1'b0;
    check("mr_busy", {31'd0, jtag_busy}, 32'h0);
    check("mr_mona", {23'd0, MonAReg}, 32'h0);
    check("mr_mond", MonDReg, 32'h0);
    avl_rd(9'h040, rd, n);
    check("mr_nowrite", rd, 32'h99);
    // Debug-access gating of Avalon writes
    avl_wr(9'h030, 32'h0, 4'hF, 1'b1);
    avl_wr(9'h030, 32'h55, 4'hF, 1'b0);
    avl_rd(9'h030, rd, n);
`ifdef SYS_CPU_OCIMEM_DEBUGACCESS_EN
    check("dbg0_rdata", rd, 32'h0);
`else
    check("dbg0_rdata", rd, 32'h55);
`endif
    avl_wr(9'h030, 32'h55, 4'hF, 1'b1);
    avl_rd(9'h030, rd, n);
    check("dbg1_rdata", rd, 32'h55);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
